// File: rtl/led_pkg.sv
// Shared widths, defaults and sequencing state type for the LED frame scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package led_pkg;
   localparam int WORD_W        = 12;
   localparam int ADDR_W        = 13;
   localparam int INDEX_W       = 10;
   localparam int FRAME_W       = 3;
   localparam int INDEX_MAX_DEF = 576;
   localparam int FRAMES_DEF    = 8;

   typedef enum logic {
      PLAY = 1'b0,
      HOLD = 1'b1
   } state_t;
endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter between the LED scan engine (default winner) and host writes.
// Latency: grants are combinational; scan data returns one cycle after a scan grant.
// Backpressure: scan_ready/wr_ready low when not granted; host forced through after STARVE_MAX waits.
module ram_arbiter
   import led_pkg::*;
#(
   parameter int INDEX_MAX  = INDEX_MAX_DEF,
   parameter int FRAMES     = FRAMES_DEF,
   parameter int STARVE_MAX = 15
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               scan_req,
   input  logic [INDEX_W-1:0] scan_index,
   input  logic [ADDR_W-1:0]  offset,
   output logic               scan_ready,
   output logic               scan_valid,
   output logic [WORD_W-1:0]  scan_data,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [WORD_W-1:0]  wr_data,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [WORD_W-1:0]  ram_wdata,
   input  logic [WORD_W-1:0]  ram_rdata
);
   localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   // One extra bit so a RAM that fills the whole address space still compares correctly.
   localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(INDEX_MAX * FRAMES);

   logic [STARVE_W-1:0] starve_cnt;
   logic                live_q;        // low for the first cycle after reset so a dropped write cannot resume
   logic                scan_valid_q;
   logic [WORD_W-1:0]   scan_data_q;
   logic                live;
   logic                host_pri;
   logic                host_gnt;
   logic                scan_gnt;
   logic                in_range;

   // Grant decision: scan by default, host when scan is idle or the host has waited too long.
   always_comb begin
      live     = live_q && !reset;
      host_pri = wr_valid && (!scan_req || (starve_cnt == STARVE_W'(STARVE_MAX)));
      host_gnt = live && host_pri;
      scan_gnt = live && scan_req && !host_pri;
      in_range = ({1'b0, wr_addr} < ADDR_LIMIT);
   end

   assign scan_ready = scan_gnt;
   assign wr_ready   = host_gnt;
   // Out-of-range host writes are still acknowledged but never reach the RAM.
   assign ram_we     = host_gnt && in_range;
   assign ram_addr   = host_gnt ? wr_addr : (offset + ADDR_W'(scan_index));
   assign ram_wdata  = wr_data;
   assign scan_valid = scan_valid_q;
   assign scan_data  = scan_valid_q ? ram_rdata : scan_data_q;

   // Starvation counter, read-return tracking and held scan data.
   always_ff @(posedge clock) begin
      if (reset) begin
         live_q       <= 1'b0;
         starve_cnt   <= '0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= '0;
      end else begin
         live_q       <= 1'b1;
         scan_valid_q <= scan_gnt;
         scan_data_q  <= scan_data;
         if (!wr_valid || host_gnt)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/frame_scheduler.sv
// LED frame scheduler: frame sequencing (PLAY/HOLD) over a shared image RAM; FRAME_SCHED_DWELL_EN adds a per-frame dwell count.
// Latency: frame advance visible the cycle after frame_done; scan data one cycle after scan grant.
// Backpressure: scan_ready/wr_ready from the arbiter; host writes forced in after STARVE_MAX waiting cycles.
module frame_scheduler
   import led_pkg::*;
#(
   parameter int INDEX_MAX  = INDEX_MAX_DEF,
   parameter int FRAMES     = FRAMES_DEF,
`ifdef FRAME_SCHED_DWELL_EN
   parameter int DWELL      = 4,
`endif
   parameter int STARVE_MAX = 15
)
(
   input  logic               clock,
   input  logic               reset,
   input  logic               scan_req,
   input  logic [INDEX_W-1:0] scan_index,
   output logic               scan_ready,
   output logic               scan_valid,
   output logic [WORD_W-1:0]  scan_data,
   input  logic               frame_done,
   input  logic               freeze,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [WORD_W-1:0]  wr_data,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [WORD_W-1:0]  ram_wdata,
   input  logic [WORD_W-1:0]  ram_rdata,
   output logic [FRAME_W-1:0] frame_sel
);
   state_t             state;
   logic [ADDR_W-1:0]  offset;        // frame_sel*INDEX_MAX, kept by repeated addition
   logic               play_evt;
   logic               advance;

`ifdef FRAME_SCHED_DWELL_EN
   localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   logic [DWELL_W-1:0] dwell_cnt;
`endif

   // A frame_done only counts in PLAY and when freeze is not rising with it.
   always_comb begin
      play_evt = (state == PLAY) && frame_done && !freeze;
`ifdef FRAME_SCHED_DWELL_EN
      advance  = play_evt && (dwell_cnt == DWELL_W'(DWELL - 1));
`else
      advance  = play_evt;
`endif
   end

   // Sequencing FSM with registered frame select, offset and dwell count.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= PLAY;
         frame_sel <= '0;
         offset    <= '0;
`ifdef FRAME_SCHED_DWELL_EN
         dwell_cnt <= '0;
`endif
      end else begin
         case (state)
            PLAY:    if (freeze)  state <= HOLD;
            HOLD:    if (!freeze) state <= PLAY;
            default: state <= PLAY;
         endcase
         if (advance) begin
            if (frame_sel == FRAME_W'(FRAMES - 1)) begin
               frame_sel <= '0;
               offset    <= '0;
            end else begin
               frame_sel <= frame_sel + 1'b1;
               offset    <= offset + ADDR_W'(INDEX_MAX);
            end
         end
`ifdef FRAME_SCHED_DWELL_EN
         // Holding does not touch the count, so a partial dwell resumes after freeze drops.
         if (play_evt)
            dwell_cnt <= advance ? '0 : dwell_cnt + 1'b1;
`endif
      end
   end

   ram_arbiter #(
      .INDEX_MAX  (INDEX_MAX),
      .FRAMES     (FRAMES),
      .STARVE_MAX (STARVE_MAX)
   ) u_arb (
      .clock      (clock),
      .reset      (reset),
      .scan_req   (scan_req),
      .scan_index (scan_index),
      .offset     (offset),
      .scan_ready (scan_ready),
      .scan_valid (scan_valid),
      .scan_data  (scan_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );
endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: vector table, hand sequences, random traffic vs. reference model.
// Latency: model predicts same-cycle grants and next-cycle scan data.
// Backpressure: model tracks host waiting time and forces grants after STARVE_MAX.
module tb_frame_scheduler;
   localparam int IMAX  = 576;
   localparam int NFR   = 8;
   localparam int SMAX  = 15;
   localparam int DEPTH = IMAX * NFR;
`ifdef FRAME_SCHED_DWELL_EN
   localparam int DWE = 4;
`else
   localparam int DWE = 1;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        scan_req;
   logic [9:0]  scan_index;
   logic        scan_ready, scan_valid;
   logic [11:0] scan_data;
   logic        frame_done, freeze;
   logic        wr_valid, wr_ready;
   logic [12:0] wr_addr;
   logic [11:0] wr_data;
   logic        ram_we;
   logic [12:0] ram_addr;
   logic [11:0] ram_wdata, ram_rdata;
   logic [2:0]  frame_sel;

   frame_scheduler dut (
      .clock(clock), .reset(reset), .scan_req(scan_req), .scan_index(scan_index),
      .scan_ready(scan_ready), .scan_valid(scan_valid), .scan_data(scan_data),
      .frame_done(frame_done), .freeze(freeze), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .frame_sel(frame_sel)
   );

   always #5 clock = ~clock;

   // Behavioural RAM, one-cycle read latency
   logic [11:0] mem    [0:DEPTH-1];
   logic [11:0] shadow [0:DEPTH-1];
   always @(posedge clock) begin
      if (ram_we && int'(ram_addr) < DEPTH) mem[ram_addr] <= ram_wdata;
      if (int'(ram_addr) < DEPTH) ram_rdata <= mem[ram_addr];
      else ram_rdata <= 12'h000;
   end

   function automatic logic [11:0] init_word(input int i);
      if (i == 5) return 12'hABC;
      return 12'((i * 37 + 11) ^ (i >> 3));
   endfunction

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model state
   int          m_frame, m_dwell, m_wait;
   bit          m_frozen_last, m_dead, m_pend;
   logic [11:0] m_pend_data, m_last_data;

   // Samples of DUT outputs from the latest step
   int s_frame_sel, s_scan_ready, s_wr_ready, s_ram_we, s_scan_valid, s_scan_data, s_ram_addr;

   task automatic model_reset();
      m_frame = 0; m_dwell = 0; m_wait = 0; m_frozen_last = 0;
      m_dead = 1; m_pend = 0; m_pend_data = '0; m_last_data = '0;
   endtask

   // One clock cycle: compare at negedge, update model at posedge.
   task automatic step();
      bit live, host_pri, e_sr, e_wr, e_we;
      int e_addr;
      logic [11:0] e_sd;
      @(negedge clock);
      live     = !reset && !m_dead;
      host_pri = wr_valid && (!scan_req || m_wait == SMAX);
      e_wr     = live && host_pri;
      e_sr     = live && scan_req && !host_pri;
      e_we     = e_wr && (int'(wr_addr) < DEPTH);
      e_addr   = e_wr ? int'(wr_addr) : m_frame * IMAX + int'(scan_index);
      e_sd     = m_pend ? m_pend_data : m_last_data;
      s_frame_sel = frame_sel; s_scan_ready = scan_ready; s_wr_ready = wr_ready;
      s_ram_we = ram_we; s_scan_valid = scan_valid; s_scan_data = scan_data; s_ram_addr = ram_addr;
      if (chk_en) begin
         chk("frame_sel", s_frame_sel, m_frame);
         chk("scan_ready", s_scan_ready, e_sr);
         chk("wr_ready", s_wr_ready, e_wr);
         chk("ram_we", s_ram_we, e_we);
         chk("scan_valid", s_scan_valid, m_pend);
         chk("scan_data", s_scan_data, e_sd);
         if (e_sr || e_wr) chk("ram_addr", s_ram_addr, e_addr);
         if (e_we) chk("ram_wdata", ram_wdata, wr_data);
      end
      @(posedge clock);
      if (reset) model_reset();
      else begin
         m_last_data = e_sd;
         m_pend = e_sr;
         if (e_sr) m_pend_data = shadow[e_addr];
         if (e_we) shadow[wr_addr] = wr_data;
         m_wait = (wr_valid && !e_wr) ? ((m_wait < SMAX) ? m_wait + 1 : SMAX) : 0;
         m_dead = 0;
         if (frame_done && !freeze && !m_frozen_last) begin
            m_dwell++;
            if (m_dwell == DWE) begin
               m_dwell = 0;
               m_frame = (m_frame + 1) % NFR;
            end
         end
         m_frozen_last = freeze;
      end
      #1;
   endtask

   task automatic pulse();
      frame_done = 1'b1; step();
      frame_done = 1'b0; step();
   endtask

   typedef struct {
      bit sreq; int sidx; bit wv; int waddr; int wdata;
      bit e_sr; bit e_wr; bit e_we; int e_addr;
   } vec_t;
   vec_t tbl [7];

   int gq[$];
   int nscan_low;
   int exp_f, prev_f;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]    = init_word(i);
         shadow[i] = init_word(i);
      end
      tbl[0] = '{1, 7,   0, 0,    0,      1, 0, 0, 7};
      tbl[1] = '{0, 0,   1, 100,  'h123,  0, 1, 1, 100};
      tbl[2] = '{1, 9,   1, 101,  'h456,  1, 0, 0, 9};
      tbl[3] = '{0, 0,   1, 4608, 'h777,  0, 1, 0, 4608};
      tbl[4] = '{0, 0,   1, 4607, 'h5A5,  0, 1, 1, 4607};
      tbl[5] = '{1, 575, 0, 0,    0,      1, 0, 0, 575};
      tbl[6] = '{0, 0,   0, 0,    0,      0, 0, 0, -1};

      reset = 1'b1; scan_req = 1'b1; scan_index = 10'd3; frame_done = 1'b0; freeze = 1'b0;
      wr_valid = 1'b1; wr_addr = 13'd10; wr_data = 12'h111;
      model_reset();
      @(posedge clock); #1;
      chk_en = 1;

      // Reset state with requests pending
      step(); step();
      chk("rst_frame_sel", s_frame_sel, 0);
      chk("rst_scan_ready", s_scan_ready, 0);
      chk("rst_wr_ready", s_wr_ready, 0);
      chk("rst_ram_we", s_ram_we, 0);
      chk("rst_scan_valid", s_scan_valid, 0);
      chk("rst_scan_data", s_scan_data, 0);
      reset = 1'b0; scan_req = 1'b0; wr_valid = 1'b0;
      step();

      // Scan only, word 5 of frame 0
      scan_req = 1'b1; scan_index = 10'd5; step();
      chk("scan_only_ready", s_scan_ready, 1);
      scan_req = 1'b0; step();
      chk("scan_only_valid", s_scan_valid, 1);
      chk("scan_only_data", s_scan_data, 'hABC);

      // Single-cycle arbitration vectors
      foreach (tbl[i]) begin
         scan_req = tbl[i].sreq; scan_index = 10'(tbl[i].sidx);
         wr_valid = tbl[i].wv; wr_addr = 13'(tbl[i].waddr); wr_data = 12'(tbl[i].wdata);
         step();
         chk("vec_scan_ready", s_scan_ready, tbl[i].e_sr);
         chk("vec_wr_ready", s_wr_ready, tbl[i].e_wr);
         chk("vec_ram_we", s_ram_we, tbl[i].e_we);
         if (tbl[i].e_addr >= 0) chk("vec_ram_addr", s_ram_addr, tbl[i].e_addr);
      end

      // Contention for 40 cycles
      nscan_low = 0;
      for (int c = 1; c <= 40; c++) begin
         scan_req = 1'b1; scan_index = 10'(c); wr_valid = 1'b1;
         wr_addr = 13'(300 + c); wr_data = 12'(c);
         step();
         if (s_wr_ready == 1) gq.push_back(c);
         if (s_scan_ready == 0) nscan_low++;
      end
      wr_valid = 1'b0; scan_req = 1'b0;
      chk("contend_grants", gq.size(), 2);
      chk("contend_scan_low", nscan_low, 2);
      if (gq.size() == 2) begin
         chk("contend_first", gq[0], 16);
         chk("contend_second", gq[1], 32);
      end
      step();

      // Frame wrap (every DWE-th pulse advances)
      scan_req = 1'b1; scan_index = 10'd0;
      for (int k = 1; k <= NFR * DWE; k++) begin
         prev_f = ((k - 1) / DWE) % NFR;
         frame_done = 1'b1; step();
         chk("done_cycle_old_offset", s_ram_addr, prev_f * IMAX);
         frame_done = 1'b0; step();
         exp_f = (k / DWE) % NFR;
         chk("wrap_frame_sel", s_frame_sel, exp_f);
         chk("wrap_offset", s_ram_addr, exp_f * IMAX);
         if (k == 7 * DWE) chk("offset_after_7th", s_ram_addr, 4032);
      end
      scan_req = 1'b0;

      // Freeze at frame 3
      for (int p = 0; p < 3 * DWE; p++) pulse();
      chk("pre_freeze_frame", s_frame_sel, 3);
      freeze = 1'b1; frame_done = 1'b1; step();
      frame_done = 1'b0; step();
      chk("freeze_with_done", s_frame_sel, 3);
      for (int p = 0; p < 5; p++) begin
         pulse();
         chk("frozen_frame", s_frame_sel, 3);
      end
      freeze = 1'b0; step();
      for (int p = 0; p < DWE; p++) pulse();
      chk("unfreeze_frame", s_frame_sel, 4);
`ifdef FRAME_SCHED_DWELL_EN
      // Partial dwell survives a hold
      pulse(); pulse();
      freeze = 1'b1; step();
      pulse(); pulse(); pulse();
      freeze = 1'b0; step();
      pulse();
      chk("dwell_partial", s_frame_sel, 4);
      pulse();
      chk("dwell_resume", s_frame_sel, 5);
`endif

      // Reset in the middle of a host write
      wr_valid = 1'b1; wr_addr = 13'd200; wr_data = 12'h3C3; scan_req = 1'b0; step();
      chk("pre_rst_we", s_ram_we, 1);
      reset = 1'b1; step();
      chk("rst_cycle_we", s_ram_we, 0);
      reset = 1'b0; step();
      chk("post_rst_we", s_ram_we, 0);
      chk("post_rst_frame", s_frame_sel, 0);
      wr_valid = 1'b0; step();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 299) == 0);
         scan_req   = ($urandom_range(0, 9) < 7);
         scan_index = 10'($urandom_range(0, IMAX - 1));
         wr_valid   = $urandom_range(0, 1) != 0;
         if ((i / 64) % 3 == 2) begin
            scan_req = 1'b1; wr_valid = 1'b1;
         end
         wr_addr    = ($urandom_range(0, 7) == 0) ? 13'($urandom_range(DEPTH, 8191))
                                                  : 13'($urandom_range(0, DEPTH - 1));
         wr_data    = 12'($urandom);
         frame_done = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 39) == 0) freeze = !freeze;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
